// File: rtl/serial_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_shifter
// Description : Parallel-in, serial-out frame transmitter. Accepts a WIDTH-bit
//               word over a valid/ready handshake and sends it as
//               start(0) + WIDTH data bits LSB-first + stop(1), with each
//               symbol held for CLKS_PER_BIT clocks. ser_out, busy and done
//               are registered; in_ready is decoded from the state register.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_shifter #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  // Counter widths never collapse to zero bits, even for 1-clock bits or
  // 1-bit words.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] C_CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] C_IDX_MAX = IW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             r_ser;
  logic             w_ser_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic             w_accept;
  logic             w_bit_end;
  logic             w_last_bit;

  // Handshake and bit-timing decodes shared by the next-state and output logic.
  assign in_ready   = (r_state == S_IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_bit_end  = (r_cnt == C_CNT_MAX);
  assign w_last_bit = (r_idx == C_IDX_MAX);

  // Right-shift of the word; a 1-bit word has nothing left to shift in.
  generate
    if (WIDTH > 1) begin : g_shift_wide
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end else begin : g_shift_single
      assign w_shifted = '0;
    end
  endgenerate

  // State register: asynchronous reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: each non-idle state advances only at a bit boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && w_last_bit) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output/datapath logic: computes the next value of every registered output
  // so the line changes on the same edge as the state that owns the symbol.
  always_comb begin
    w_ser_nxt   = r_ser;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    case (r_state)
      S_IDLE: begin
        w_ser_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
        w_idx_nxt  = '0;
        if (w_accept) begin
          // The word is captured here and never sampled again this frame.
          w_shreg_nxt = in_data;
          w_ser_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          w_ser_nxt = r_shreg[0];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (w_last_bit) begin
            w_ser_nxt = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_shreg_nxt = w_shifted;
            w_ser_nxt   = w_shifted[0];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt  = '0;
          w_ser_nxt  = 1'b1;
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_ser_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
        w_idx_nxt  = '0;
      end
    endcase
  end

  // Datapath and output registers: reset drives the line to its idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_ser   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
      r_ser   <= w_ser_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign ser_out = r_ser;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_shifter
// Description : Self-checking bench for serial_tx_shifter (WIDTH=8 with
//               CLKS_PER_BIT=4, plus a CLKS_PER_BIT=1 instance) against a
//               frame-offset reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_shifter;

  localparam int W     = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (W + 2) * CPB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, ser_out, busy, done;
  logic [W-1:0] in_data1 = '0;
  logic         in_valid1 = 1'b0;
  logic         in_ready1, ser_out1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame is a flag, the cycle offset since acceptance
  // and the captured word; the line value is looked up from the offset.
  bit           m_active = 1'b0;
  bit           m_done   = 1'b0;
  int           m_t      = 0;
  logic [W-1:0] m_word   = '0;

  serial_tx_shifter #(.WIDTH(W), .CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .busy(busy), .done(done)
  );

  serial_tx_shifter #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .ser_out(ser_out1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  function automatic logic exp_ser();
    int sym;
    if (!m_active) return 1'b1;
    sym = m_t / CPB;
    if (sym == 0) return 1'b0;
    if (sym <= W) return m_word[sym-1];
    return 1'b1;
  endfunction

  // One clock: advance the model on the rising edge, return on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (!m_active && in_valid) begin
      m_active = 1'b1;
      m_t      = 0;
      m_word   = in_data;
      m_done   = 1'b0;
    end else if (m_active) begin
      m_t++;
      if (m_t == FRAME) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks += 4;
      if (ser_out !== 1'b1) begin n_fail++; $display("FAIL reset ser_out got %b exp 1", ser_out); end
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
      if (done !== 1'b0)    begin n_fail++; $display("FAIL reset done got %b exp 0", done); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
    end
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks += 2;
    if (busy !== 1'b1)    begin n_fail++; $display("FAIL reset_accept busy got %b exp 1", busy); end
    if (ser_out !== 1'b0) begin n_fail++; $display("FAIL reset_accept ser_out got %b exp 0", ser_out); end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_checks += 3;
      if (ser_out !== exp_ser()) begin n_fail++; $display("FAIL reset_frame ser_out t=%0t got %b exp %b", $time, ser_out, exp_ser()); end
      if (busy !== m_active)     begin n_fail++; $display("FAIL reset_frame busy t=%0t got %b exp %b", $time, busy, m_active); end
      if (done !== m_done)       begin n_fail++; $display("FAIL reset_frame done t=%0t got %b exp %b", $time, done, m_done); end
    end
  endtask

  task automatic test_single_frame();
    logic [W+1:0] line;
    int           busy_cnt;
    int           done_at;
    line     = {1'b1, 8'hA5, 1'b0};
    busy_cnt = 0;
    done_at  = -1;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int off = 0; off <= FRAME; off++) begin
      if (off > 0) tick();
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && done_at < 0) done_at = off;
      n_checks += 4;
      if (ser_out !== exp_ser()) begin n_fail++; $display("FAIL single ser_out off=%0d got %b exp %b", off, ser_out, exp_ser()); end
      if (busy !== m_active)     begin n_fail++; $display("FAIL single busy off=%0d got %b exp %b", off, busy, m_active); end
      if (done !== m_done)       begin n_fail++; $display("FAIL single done off=%0d got %b exp %b", off, done, m_done); end
      if (in_ready !== !m_active) begin n_fail++; $display("FAIL single in_ready off=%0d got %b exp %b", off, in_ready, !m_active); end
      if (off < FRAME && (off % CPB) == CPB - 1) begin
        n_checks++;
        if (ser_out !== line[off/CPB]) begin n_fail++; $display("FAIL single symbol %0d got %b exp %b", off/CPB, ser_out, line[off/CPB]); end
      end
    end
    n_checks += 2;
    if (busy_cnt !== FRAME) begin n_fail++; $display("FAIL single busy_len got %0d exp %0d", busy_cnt, FRAME); end
    if (done_at !== FRAME)  begin n_fail++; $display("FAIL single done_at got %0d exp %0d", done_at, FRAME); end
  endtask

  task automatic test_back_to_back();
    int ones;
    ones     = 0;
    in_data  = 8'h00;
    in_valid = 1'b1;
    tick();
    in_data = 8'hFF;
    for (int off = 1; off <= 2 * FRAME + 1; off++) begin
      tick();
      if (off == FRAME + 1) in_valid = 1'b0;
      n_checks += 3;
      if (ser_out !== exp_ser()) begin n_fail++; $display("FAIL b2b ser_out off=%0d got %b exp %b", off, ser_out, exp_ser()); end
      if (busy !== m_active)     begin n_fail++; $display("FAIL b2b busy off=%0d got %b exp %b", off, busy, m_active); end
      if (done !== m_done)       begin n_fail++; $display("FAIL b2b done off=%0d got %b exp %b", off, done, m_done); end
      if (off == FRAME) begin
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b done_ready got %b exp 1", in_ready); end
        if (done !== 1'b1)     begin n_fail++; $display("FAIL b2b done_pulse got %b exp 1", done); end
      end
      if (off == FRAME + 1) begin
        n_checks += 2;
        if (ser_out !== 1'b0) begin n_fail++; $display("FAIL b2b start2 ser_out got %b exp 0", ser_out); end
        if (busy !== 1'b1)    begin n_fail++; $display("FAIL b2b start2 busy got %b exp 1", busy); end
      end
      if (off > FRAME + 1 + CPB && off <= 2 * FRAME + 1 - CPB && ser_out === 1'b1) ones++;
    end
    n_checks++;
    if (ones !== W * CPB) begin n_fail++; $display("FAIL b2b data_ones got %0d exp %0d", ones, W * CPB); end
  endtask

  task automatic test_isolation();
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int off = 1; off <= FRAME + 3; off++) begin
      tick();
      if (off == 12) begin in_data = 8'h00; in_valid = 1'b1; end
      if (off == 13) in_valid = 1'b0;
      n_checks += 3;
      if (ser_out !== exp_ser()) begin n_fail++; $display("FAIL iso ser_out off=%0d got %b exp %b", off, ser_out, exp_ser()); end
      if (busy !== m_active)     begin n_fail++; $display("FAIL iso busy off=%0d got %b exp %b", off, busy, m_active); end
      if (done !== m_done)       begin n_fail++; $display("FAIL iso done off=%0d got %b exp %b", off, done, m_done); end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL iso second_frame busy got %b exp 0", busy); end
  endtask

  task automatic test_mid_reset();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int off = 1; off <= 13; off++) tick();
    rst_n    = 1'b0;
    m_active = 1'b0;
    m_done   = 1'b0;
    #1;
    n_checks += 3;
    if (ser_out !== 1'b1)  begin n_fail++; $display("FAIL midrst ser_out got %b exp 1", ser_out); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL midrst busy got %b exp 0", busy); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready got %b exp 1", in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL midrst stray_done got %b exp 0", done); end
    end
    in_data  = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int off = 1; off <= FRAME; off++) begin
      tick();
      n_checks += 3;
      if (ser_out !== exp_ser()) begin n_fail++; $display("FAIL midrst_5a ser_out off=%0d got %b exp %b", off, ser_out, exp_ser()); end
      if (busy !== m_active)     begin n_fail++; $display("FAIL midrst_5a busy off=%0d got %b exp %b", off, busy, m_active); end
      if (done !== m_done)       begin n_fail++; $display("FAIL midrst_5a done off=%0d got %b exp %b", off, done, m_done); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = W'($urandom);
      tick();
      n_checks += 4;
      if (ser_out !== exp_ser()) begin n_fail++; $display("FAIL rand ser_out c=%0d got %b exp %b", c, ser_out, exp_ser()); end
      if (busy !== m_active)     begin n_fail++; $display("FAIL rand busy c=%0d got %b exp %b", c, busy, m_active); end
      if (done !== m_done)       begin n_fail++; $display("FAIL rand done c=%0d got %b exp %b", c, done, m_done); end
      if (in_ready !== !m_active) begin n_fail++; $display("FAIL rand in_ready c=%0d got %b exp %b", c, in_ready, !m_active); end
    end
    in_valid = 1'b0;
    for (int c = 0; c < FRAME + 1; c++) tick();
  endtask

  task automatic test_cpb1();
    logic [W+1:0] line;
    line      = {1'b1, 8'h81, 1'b0};
    in_data1  = 8'h81;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int off = 0; off <= W + 2; off++) begin
      if (off > 0) tick();
      n_checks += 2;
      if (off < W + 2) begin
        if (ser_out1 !== line[off]) begin n_fail++; $display("FAIL cpb1 ser_out off=%0d got %b exp %b", off, ser_out1, line[off]); end
        if (done1 !== 1'b0)         begin n_fail++; $display("FAIL cpb1 done off=%0d got %b exp 0", off, done1); end
      end else begin
        if (done1 !== 1'b1) begin n_fail++; $display("FAIL cpb1 done_at off=%0d got %b exp 1", off, done1); end
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL cpb1 busy_end got %b exp 0", busy1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    tick();
    test_isolation();
    test_mid_reset();
    tick();
    test_random();
    test_cpb1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
